sensor_hub_controller: RTL and testbench

- Serial-command front end for up to NUM_SENSORS DHT-style sensors on the 9600 Hz byte link.
- Takes a wake byte, an address byte and a command byte from the UART receiver, then triggers the addressed sensor and waits for its 40-bit frame.
- Checks the frame checksum, then streams a header byte, zero to four data bytes and an end byte to the UART transmitter.
- Adds sensor addressing, checksum checking, a combined temperature+humidity mode, an inactivity timeout and parametrised timing.

---
 rtl/sensor_hub_controller_if.sv | 27 ++
 rtl/sensor_hub_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_sensor_hub_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sensor_hub_controller_if.sv
// Byte-link and sensor-side signal bundle for the sensor hub controller.
// Latency: none (wires only).
// Backpressure: none; tx_start/data_received are single-cycle strobes with no handshake.
interface sensor_hub_controller_if #(
    parameter int NUM_SENSORS = 4
) ();
    logic [7:0]               data_in;
    logic                     data_received;
    logic [40*NUM_SENSORS-1:0] sensor_data;
    logic [NUM_SENSORS-1:0]   sensor_error;
    logic [NUM_SENSORS-1:0]   start_sensor;
    logic [7:0]               data_out;
    logic                     tx_start;
    logic                     busy;

    // Host side: UART receiver and sensor interfaces drive, transmitter consumes.
    modport master (
        output data_in, data_received, sensor_data, sensor_error,
        input  start_sensor, data_out, tx_start, busy
    );

    // Controller side.
    modport slave (
        input  data_in, data_received, sensor_data, sensor_error,
        output start_sensor, data_out, tx_start, busy
    );
endinterface

// File: rtl/sensor_hub_controller.sv
// Wake/address/command front end that triggers a sensor, checks its frame and streams the reply.
// Latency: every response output is registered one edge after the state that produces it.
// Backpressure: none; received bytes outside SLEEP/WAIT_ADDRESS/WAIT_COMMAND are dropped.
module sensor_hub_controller #(
    parameter int NUM_SENSORS  = 4,
    parameter int SENSOR_WAIT  = 213,
    parameter int BYTE_GAP     = 11,
    parameter int IDLE_TIMEOUT = 9600
) (
    input  logic                    clk_9600hz,
    input  logic                    reset,
    sensor_hub_controller_if.slave  bus
);
    // One shared counter serves the idle timeout, the sensor wait and the byte gap.
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + SENSOR_WAIT + BYTE_GAP + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SENSOR_LAST = CNT_W'(SENSOR_WAIT);
    // The emitting state itself is the last cycle of the gap, so wait BYTE_GAP-1 cycles.
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(BYTE_GAP - 2);

    typedef enum logic [3:0] {
        S_SLEEP,
        S_ACK,
        S_WAIT_ADDRESS,
        S_WAIT_COMMAND,
        S_WAIT_SENSOR,
        S_CAPTURE,
        S_HEADER,
        S_GAP_WAIT,
        S_DATA,
        S_END
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [7:0]             r_addr, w_addr_nxt;
    logic [7:0]             r_cmd, w_cmd_nxt;
    logic [7:0]             r_header, w_header_nxt;
    logic [31:0]            r_payload, w_payload_nxt;
    logic [2:0]             r_left, w_left_nxt;
    logic [NUM_SENSORS-1:0] r_start, w_start_nxt;
    logic                   r_tx, w_tx_nxt;
    logic [7:0]             r_dout, w_dout_nxt;

    logic [39:0]            w_frame;
    logic                   w_err;
    logic [NUM_SENSORS-1:0] w_onehot;
    logic [7:0]             w_sum;
    logic                   w_fault;

    // Select the addressed sensor's frame, error flag and trigger bit.
    always_comb begin
        w_frame  = '0;
        w_err    = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (r_addr == 8'(i)) begin
                w_frame     = bus.sensor_data[40*i +: 40];
                w_err       = bus.sensor_error[i];
                w_onehot[i] = 1'b1;
            end
        end
        w_sum   = w_frame[39:32] + w_frame[31:24] + w_frame[23:16] + w_frame[15:8];
        w_fault = w_err | (w_sum != w_frame[7:0]);
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_9600hz or posedge reset) begin
        if (reset) begin
            r_state   <= S_SLEEP;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_cmd     <= '0;
            r_header  <= '0;
            r_payload <= '0;
            r_left    <= '0;
            r_start   <= '0;
            r_tx      <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_cmd     <= w_cmd_nxt;
            r_header  <= w_header_nxt;
            r_payload <= w_payload_nxt;
            r_left    <= w_left_nxt;
            r_start   <= w_start_nxt;
            r_tx      <= w_tx_nxt;
            r_dout    <= w_dout_nxt;
        end
    end

    // Next-state and next-output decode for the transaction sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_cmd_nxt     = r_cmd;
        w_header_nxt  = r_header;
        w_payload_nxt = r_payload;
        w_left_nxt    = r_left;
        w_start_nxt   = '0;
        w_tx_nxt      = 1'b0;
        w_dout_nxt    = r_dout;

        case (r_state)
            S_SLEEP: begin
                if (bus.data_received && bus.data_in == 8'h00) begin
                    w_state_nxt = S_ACK;
                end
            end

            S_ACK: begin
                w_tx_nxt    = 1'b1;
                w_dout_nxt  = 8'h01;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_ADDRESS;
            end

            S_WAIT_ADDRESS: begin
                if (bus.data_received) begin
                    w_addr_nxt = bus.data_in;
                    w_cnt_nxt  = '0;
                    if ({24'd0, bus.data_in} >= NUM_SENSORS) begin
                        // Unknown sensor: report it without waiting for a command.
                        w_header_nxt = 8'hE0;
                        w_left_nxt   = '0;
                        w_state_nxt  = S_HEADER;
                    end else begin
                        w_state_nxt = S_WAIT_COMMAND;
                    end
                end else if (r_cnt == IDLE_LAST) begin
                    w_state_nxt = S_SLEEP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_WAIT_COMMAND: begin
                if (bus.data_received) begin
                    w_cmd_nxt = bus.data_in;
                    w_cnt_nxt = '0;
                    if (bus.data_in[7:2] == 6'b000001) begin
                        w_state_nxt = S_WAIT_SENSOR;
                    end else begin
                        w_header_nxt = 8'hFF;
                        w_left_nxt   = '0;
                        w_state_nxt  = S_HEADER;
                    end
                end else if (r_cnt == IDLE_LAST) begin
                    w_state_nxt = S_SLEEP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_WAIT_SENSOR: begin
                // Trigger on the first cycle, then let the sensor settle.
                if (r_cnt == '0) begin
                    w_start_nxt = w_onehot;
                end
                if (r_cnt == SENSOR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_CAPTURE: begin
                // Payload is left-aligned so DATA always sends the top byte.
                case (r_cmd)
                    8'h04: begin
                        w_header_nxt  = 8'h02;
                        w_payload_nxt = {w_frame[23:8], 16'h0000};
                        w_left_nxt    = 3'd2;
                    end
                    8'h05: begin
                        w_header_nxt  = 8'h01;
                        w_payload_nxt = {w_frame[39:24], 16'h0000};
                        w_left_nxt    = 3'd2;
                    end
                    8'h06: begin
                        w_header_nxt  = 8'h00;
                        w_payload_nxt = '0;
                        w_left_nxt    = 3'd0;
                    end
                    default: begin
                        w_header_nxt  = 8'h03;
                        w_payload_nxt = w_frame[39:8];
                        w_left_nxt    = 3'd4;
                    end
                endcase
                if (w_fault) begin
                    w_header_nxt  = 8'h0F;
                    w_payload_nxt = '0;
                    w_left_nxt    = 3'd0;
                end
                w_state_nxt = S_HEADER;
            end

            S_HEADER: begin
                w_tx_nxt    = 1'b1;
                w_dout_nxt  = r_header;
                w_cnt_nxt   = '0;
                w_state_nxt = S_GAP_WAIT;
            end

            S_GAP_WAIT: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_left != 3'd0) ? S_DATA : S_END;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                w_tx_nxt      = 1'b1;
                w_dout_nxt    = r_payload[31:24];
                w_payload_nxt = {r_payload[23:0], 8'h00};
                w_left_nxt    = r_left - 3'd1;
                w_cnt_nxt     = '0;
                w_state_nxt   = S_GAP_WAIT;
            end

            S_END: begin
                w_tx_nxt    = 1'b1;
                w_dout_nxt  = 8'hF0;
                w_state_nxt = S_SLEEP;
            end

            default: begin
                w_state_nxt = S_SLEEP;
            end
        endcase
    end

    assign bus.start_sensor = r_start;
    assign bus.tx_start     = r_tx;
    assign bus.data_out     = r_dout;
    assign bus.busy         = (r_state != S_SLEEP);

endmodule

// File: tb/tb_sensor_hub_controller.sv
// Scoreboard bench: stimulus pushes expected tx bytes and triggers, monitor pops and checks.
// Latency: checks byte spacing of BYTE_GAP between successive reply bytes.
// Backpressure: none; the bench never stalls the DUT.
module tb_sensor_hub_controller;
    localparam int NS = 4;
    localparam int SW = 213;
    localparam int BG = 11;
    localparam int IT = 9600;

    logic clk_9600hz = 1'b0;
    logic reset      = 1'b1;

    sensor_hub_controller_if #(.NUM_SENSORS(NS)) bus ();

    sensor_hub_controller #(
        .NUM_SENSORS (NS),
        .SENSOR_WAIT (SW),
        .BYTE_GAP    (BG),
        .IDLE_TIMEOUT(IT)
    ) dut (
        .clk_9600hz(clk_9600hz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_9600hz = ~clk_9600hz;

    typedef struct {
        logic [7:0] b;
        bit         gap;
    } exp_t;

    exp_t           exp_q[$];
    logic [NS-1:0]  start_q[$];
    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int last_tx  = 0;
    int n_popped = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: every tx_start and start_sensor observation is matched against the queues.
    always @(negedge clk_9600hz) begin : monitor
        exp_t e;
        cyc++;
        if (!reset) begin
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx: got %0h expected none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", int'(bus.data_out), int'(e.b));
                    if (e.gap) chk("tx_gap", cyc - last_tx, BG);
                end
                last_tx = cyc;
                n_popped++;
            end
            if (bus.start_sensor != '0) begin
                if (start_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got %0h expected none", bus.start_sensor);
                end else begin
                    chk("start_sensor", int'(bus.start_sensor), int'(start_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_9600hz);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_9600hz);
        bus.data_in       = b;
        bus.data_received = 1'b1;
        @(negedge clk_9600hz);
        bus.data_received = 1'b0;
        bus.data_in       = 8'h5A;
    endtask

    task automatic wait_done(input string nm);
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk_9600hz);
            if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
        end
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_start_left"}, start_q.size(), 0);
        exp_q.delete();
        start_q.delete();
        idle(3);
    endtask

    // Full wake/address/command transaction; exp_b holds n reply bytes MSB first.
    task automatic run_txn(input string nm, input logic [7:0] addr, input logic [7:0] cmd,
                           input logic [39:0] frame, input logic [NS-1:0] errs,
                           input logic [NS-1:0] exp_start, input int n,
                           input logic [47:0] exp_b, input bit finish_it);
        for (int i = 0; i < NS; i++) begin
            bus.sensor_data[40*i +: 40] = (i == int'(addr)) ? frame : 40'h11_22_33_44_AA;
        end
        bus.sensor_error = errs;
        exp_q.push_back('{b: 8'h01, gap: 1'b0});
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{b: exp_b[47-8*k -: 8], gap: (k > 0)});
        end
        if (exp_start != '0) start_q.push_back(exp_start);
        send_byte(8'h00);
        idle(3);
        send_byte(addr);
        idle(2);
        send_byte(cmd);
        if (finish_it) wait_done(nm);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int target;
        bit hit;
        bus.data_in       = 8'h00;
        bus.data_received = 1'b0;
        bus.sensor_data   = '0;
        bus.sensor_error  = '0;
        idle(2);
        reset = 1'b0;
        @(negedge clk_9600hz);
        chk("rst_tx_start", int'(bus.tx_start), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_start", int'(bus.start_sensor), 0);

        // Non-wake byte in SLEEP is ignored.
        send_byte(8'h42);
        idle(3);
        chk("ignore_busy", int'(bus.busy), 0);

        // Wake then silence: acknowledge, then drop back to SLEEP after the idle timeout.
        exp_q.push_back('{b: 8'h01, gap: 1'b0});
        send_byte(8'h00);
        idle(5);
        chk("wake_busy", int'(bus.busy), 1);
        idle(IT - 20);
        chk("pre_timeout_busy", int'(bus.busy), 1);
        idle(40);
        chk("timeout_busy", int'(bus.busy), 0);
        chk("timeout_exp_left", exp_q.size(), 0);
        exp_q.delete();

        run_txn("temp", 8'd2, 8'h04, 40'h37_00_19_05_55, 4'b0001, 4'b0100,
                4, 48'h02_19_05_F0_00_00, 1'b1);
        run_txn("combined", 8'd1, 8'h07, 40'hFF_01_FF_02_01, 4'b0000, 4'b0010,
                6, 48'h03_FF_01_FF_02_F0, 1'b1);
        run_txn("hum", 8'd3, 8'h05, 40'h37_00_19_05_55, 4'b0000, 4'b1000,
                4, 48'h01_37_00_F0_00_00, 1'b1);
        run_txn("bad_ck", 8'd0, 8'h04, 40'h37_00_19_05_00, 4'b0000, 4'b0001,
                2, 48'h0F_F0_00_00_00_00, 1'b1);
        run_txn("sens_err", 8'd3, 8'h05, 40'h37_00_19_05_55, 4'b1000, 4'b1000,
                2, 48'h0F_F0_00_00_00_00, 1'b1);
        run_txn("bad_addr", 8'h09, 8'h04, 40'h37_00_19_05_55, 4'b0000, 4'b0000,
                2, 48'hE0_F0_00_00_00_00, 1'b1);
        run_txn("addr_edge", 8'h04, 8'h04, 40'h37_00_19_05_55, 4'b0000, 4'b0000,
                2, 48'hE0_F0_00_00_00_00, 1'b1);
        run_txn("bad_cmd", 8'd1, 8'h33, 40'h37_00_19_05_55, 4'b0000, 4'b0000,
                2, 48'hFF_F0_00_00_00_00, 1'b1);

        // Reset between data bytes: outputs clear at once and no end byte follows.
        target = n_popped + 3;
        run_txn("rst_mid", 8'd2, 8'h04, 40'h37_00_19_05_55, 4'b0000, 4'b0100,
                4, 48'h02_19_05_F0_00_00, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(negedge clk_9600hz);
            if (n_popped >= target) hit = 1'b1;
        end
        chk("rst_mid_reached", int'(hit), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", int'(bus.tx_start), 0);
        chk("rst_mid_dout", int'(bus.data_out), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_start", int'(bus.start_sensor), 0);
        exp_q.delete();
        start_q.delete();
        @(negedge clk_9600hz);
        reset = 1'b0;
        idle(3 * BG);

        run_txn("after_rst", 8'd2, 8'h06, 40'h37_00_19_05_55, 4'b0000, 4'b0100,
                2, 48'h00_F0_00_00_00_00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
